// File: rtl/intc_claim_arb.sv
`default_nettype none
// ============================================================================
//  Module   : intc_claim_arb
//  Purpose  : Interrupt claim/complete arbiter. Masks pending sources with a
//             per-source enable, excludes in-service sources, picks the
//             lowest-index eligible source and raises irq. A claim/complete
//             handshake tracks which sources are in service.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             int_pend_i        - level pending vector
//             int_en_i          - per-source enable mask
//             irq_o             - interrupt request to the core
//             claim_req_i       - single-cycle claim request
//             claim_valid_o     - claim response strobe (one cycle)
//             claim_hit_o       - 1 = a source was granted
//             claim_id_o        - granted source ID (0 when no hit)
//             cmpl_valid_i      - completion strobe
//             cmpl_id_i         - completed source ID
//             cmpl_err_o        - pulse on completion of a non-serviced source
//             in_service_o      - in-service bitmap
//             nout_o            - number of sources in service
//  Revision : 1.0 - initial release
// ============================================================================
module intc_claim_arb #(
  parameter int NSRC = 64,
  parameter int IDW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] int_pend_i,
  input  logic [NSRC-1:0] int_en_i,
  output logic            irq_o,
  input  logic            claim_req_i,
  output logic            claim_valid_o,
  output logic            claim_hit_o,
  output logic [IDW-1:0]  claim_id_o,
  input  logic            cmpl_valid_i,
  input  logic [IDW-1:0]  cmpl_id_i,
  output logic            cmpl_err_o,
  output logic [NSRC-1:0] in_service_o,
  output logic [IDW:0]    nout_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t          state_q;
  logic            cand_valid_q;
  logic [IDW-1:0]  cand_id_q;
  logic [NSRC-1:0] in_service_q;
  logic [NSRC-1:0] in_service_d;
  logic [IDW:0]    nout_q;
  logic [IDW:0]    nout_d;
  logic            claim_valid_q;
  logic            claim_hit_q;
  logic [IDW-1:0]  claim_id_q;
  logic            cmpl_err_q;

  logic [NSRC-1:0] w_elig;
  logic            w_cand_valid;
  logic [IDW-1:0]  w_cand_id;
  logic            w_grant;
  logic [NSRC-1:0] w_set_mask;
  logic [NSRC-1:0] w_clr_mask;
  logic            w_cmpl_hit;

  // Lowest-index eligible source: scanning downward lets the last hit win.
  always_comb begin
    w_elig       = int_pend_i & int_en_i & ~in_service_q;
    w_cand_valid = 1'b0;
    w_cand_id    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_cand_valid = 1'b1;
        w_cand_id    = IDW'(i);
      end
    end
  end

  // Set/clear masks. IDs outside 0..NSRC-1 match no bit, so they count as
  // not in service and raise cmpl_err. A grant always wins over a clear of
  // the same bit; the granted bit cannot already be set, so such a
  // completion is spurious anyway.
  always_comb begin
    w_grant    = (state_q == S_IDLE) && claim_req_i && cand_valid_q;
    w_set_mask = '0;
    w_clr_mask = '0;
    w_cmpl_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_grant && (cand_id_q == IDW'(i))) begin
        w_set_mask[i] = 1'b1;
      end
      if (cmpl_valid_i && (cmpl_id_i == IDW'(i))) begin
        w_clr_mask[i] = 1'b1;
        if (in_service_q[i]) begin
          w_cmpl_hit = 1'b1;
        end
      end
    end
    in_service_d = (in_service_q & ~w_clr_mask) | w_set_mask;
  end

  // Occupancy count: a simultaneous grant and valid completion cancel out.
  always_comb begin
    nout_d = nout_q;
    if (w_grant && !w_cmpl_hit && (nout_q != (IDW+1)'(NSRC))) begin
      nout_d = nout_q + (IDW+1)'(1);
    end else if (!w_grant && w_cmpl_hit && (nout_q != '0)) begin
      nout_d = nout_q - (IDW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cand_valid_q  <= 1'b0;
      cand_id_q     <= '0;
      in_service_q  <= '0;
      nout_q        <= '0;
      claim_valid_q <= 1'b0;
      claim_hit_q   <= 1'b0;
      claim_id_q    <= '0;
      cmpl_err_q    <= 1'b0;
    end else begin
      cand_valid_q  <= w_cand_valid;
      cand_id_q     <= w_cand_id;
      in_service_q  <= in_service_d;
      nout_q        <= nout_d;
      cmpl_err_q    <= cmpl_valid_i && !w_cmpl_hit;
      claim_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (claim_req_i) begin
            // Grant is fixed here; later pend changes do not revoke it.
            claim_hit_q <= cand_valid_q;
            claim_id_q  <= cand_valid_q ? cand_id_q : '0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          // Requests arriving here are dropped.
          claim_valid_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign irq_o         = cand_valid_q;
  assign claim_valid_o = claim_valid_q;
  assign claim_hit_o   = claim_hit_q;
  assign claim_id_o    = claim_id_q;
  assign cmpl_err_o    = cmpl_err_q;
  assign in_service_o  = in_service_q;
  assign nout_o        = nout_q;

endmodule
`default_nettype wire

// File: tb/tb_intc_claim_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intc_claim_arb
//  Purpose  : Directed self-checking bench for intc_claim_arb.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_intc_claim_arb;

  logic        clk;
  logic        rst;
  logic [63:0] int_pend;
  logic [63:0] int_en;
  logic        irq;
  logic        claim_req;
  logic        claim_valid;
  logic        claim_hit;
  logic [5:0]  claim_id;
  logic        cmpl_valid;
  logic [5:0]  cmpl_id;
  logic        cmpl_err;
  logic [63:0] in_service;
  logic [6:0]  nout;

  int n_checks = 0;
  int n_errors = 0;

  intc_claim_arb #(.NSRC(64), .IDW(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .int_pend_i    (int_pend),
    .int_en_i      (int_en),
    .irq_o         (irq),
    .claim_req_i   (claim_req),
    .claim_valid_o (claim_valid),
    .claim_hit_o   (claim_hit),
    .claim_id_o    (claim_id),
    .cmpl_valid_i  (cmpl_valid),
    .cmpl_id_i     (cmpl_id),
    .cmpl_err_o    (cmpl_err),
    .in_service_o  (in_service),
    .nout_o        (nout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    int_pend   = '0;
    int_en     = '0;
    claim_req  = 1'b0;
    cmpl_valid = 1'b0;
    cmpl_id    = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One-cycle claim request; returns in the claim_valid cycle.
  task automatic claim_pulse();
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL rst_irq got=%0b exp=0", irq); end
    n_checks++; if (claim_valid !== 1'b0 || claim_hit !== 1'b0 || claim_id !== 6'd0) begin
      n_errors++; $display("FAIL rst_claim got v=%0b h=%0b id=%0d exp 0/0/0", claim_valid, claim_hit, claim_id); end
    n_checks++; if (cmpl_err !== 1'b0) begin n_errors++; $display("FAIL rst_cmpl_err got=%0b exp=0", cmpl_err); end
    n_checks++; if (in_service !== 64'h0 || nout !== 7'd0) begin
      n_errors++; $display("FAIL rst_state got insvc=%h nout=%0d exp 0/0", in_service, nout); end
  endtask

  task automatic test_basic();
    do_reset();
    int_pend = 64'h28;
    int_en   = '1;
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL basic_irq_pre got=%0b exp=0", irq); end
    tick();
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL basic_irq_lat got=%0b exp=1", irq); end
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    n_checks++; if (claim_valid !== 1'b0) begin n_errors++; $display("FAIL basic_resp_early got=%0b exp=0", claim_valid); end
    tick();
    n_checks++; if (claim_valid !== 1'b1 || claim_hit !== 1'b1 || claim_id !== 6'd3) begin
      n_errors++; $display("FAIL basic_claim1 got v=%0b h=%0b id=%0d exp 1/1/3", claim_valid, claim_hit, claim_id); end
    n_checks++; if (in_service !== 64'h08 || nout !== 7'd1) begin
      n_errors++; $display("FAIL basic_state1 got insvc=%h nout=%0d exp 08/1", in_service, nout); end
    claim_pulse();
    n_checks++; if (claim_valid !== 1'b1 || claim_hit !== 1'b1 || claim_id !== 6'd5 || nout !== 7'd2) begin
      n_errors++; $display("FAIL basic_claim2 got v=%0b h=%0b id=%0d nout=%0d exp 1/1/5/2", claim_valid, claim_hit, claim_id, nout); end
    claim_pulse();
    n_checks++; if (claim_valid !== 1'b1 || claim_hit !== 1'b0 || claim_id !== 6'd0 || irq !== 1'b0) begin
      n_errors++; $display("FAIL basic_claim3 got v=%0b h=%0b id=%0d irq=%0b exp 1/0/0/0", claim_valid, claim_hit, claim_id, irq); end
    cmpl_valid = 1'b1;
    cmpl_id    = 6'd3;
    tick();
    cmpl_valid = 1'b0;
    n_checks++; if (in_service !== 64'h20 || nout !== 7'd1 || cmpl_err !== 1'b0) begin
      n_errors++; $display("FAIL basic_cmpl got insvc=%h nout=%0d err=%0b exp 20/1/0", in_service, nout, cmpl_err); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL basic_irq_early got=%0b exp=0", irq); end
    tick();
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL basic_irq_back got=%0b exp=1", irq); end
  endtask

  task automatic test_enable();
    do_reset();
    int_pend = 64'h1 << 10;
    int_en   = ~(64'h1 << 10);
    tick();
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL en_masked_irq got=%0b exp=0", irq); end
    claim_pulse();
    n_checks++; if (claim_valid !== 1'b1 || claim_hit !== 1'b0 || claim_id !== 6'd0 || nout !== 7'd0) begin
      n_errors++; $display("FAIL en_masked_claim got v=%0b h=%0b id=%0d nout=%0d exp 1/0/0/0", claim_valid, claim_hit, claim_id, nout); end
    int_en = '1;
    tick();
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL en_irq got=%0b exp=1", irq); end
    claim_pulse();
    n_checks++; if (claim_valid !== 1'b1 || claim_hit !== 1'b1 || claim_id !== 6'd10) begin
      n_errors++; $display("FAIL en_claim got v=%0b h=%0b id=%0d exp 1/1/10", claim_valid, claim_hit, claim_id); end
    n_checks++; if (in_service !== (64'h1 << 10) || nout !== 7'd1) begin
      n_errors++; $display("FAIL en_state got insvc=%h nout=%0d exp %h/1", in_service, nout, 64'h1 << 10); end
  endtask

  task automatic test_cmpl_err();
    do_reset();
    cmpl_valid = 1'b1;
    cmpl_id    = 6'd7;
    tick();
    cmpl_valid = 1'b0;
    n_checks++; if (cmpl_err !== 1'b1 || in_service !== 64'h0 || nout !== 7'd0) begin
      n_errors++; $display("FAIL err_pulse got err=%0b insvc=%h nout=%0d exp 1/0/0", cmpl_err, in_service, nout); end
    tick();
    n_checks++; if (cmpl_err !== 1'b0) begin n_errors++; $display("FAIL err_one_cycle got=%0b exp=0", cmpl_err); end
    int_pend = 64'h4;
    int_en   = '1;
    tick();
    claim_req  = 1'b1;
    cmpl_valid = 1'b1;
    cmpl_id    = 6'd2;
    tick();
    claim_req  = 1'b0;
    cmpl_valid = 1'b0;
    n_checks++; if (cmpl_err !== 1'b1 || in_service !== 64'h4 || nout !== 7'd1) begin
      n_errors++; $display("FAIL same_id got err=%0b insvc=%h nout=%0d exp 1/4/1", cmpl_err, in_service, nout); end
    tick();
    n_checks++; if (claim_valid !== 1'b1 || claim_hit !== 1'b1 || claim_id !== 6'd2 || cmpl_err !== 1'b0) begin
      n_errors++; $display("FAIL same_id_resp got v=%0b h=%0b id=%0d err=%0b exp 1/1/2/0", claim_valid, claim_hit, claim_id, cmpl_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    int_pend = 64'h1 << 9;
    int_en   = '1;
    tick();
    claim_pulse();
    n_checks++; if (claim_id !== 6'd9 || nout !== 7'd1) begin
      n_errors++; $display("FAIL b2b_first got id=%0d nout=%0d exp 9/1", claim_id, nout); end
    int_pend = (64'h1 << 9) | (64'h1 << 4);
    tick();
    claim_req  = 1'b1;
    cmpl_valid = 1'b1;
    cmpl_id    = 6'd9;
    tick();
    cmpl_valid = 1'b0;
    n_checks++; if (in_service !== 64'h10 || nout !== 7'd1 || cmpl_err !== 1'b0 || claim_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_swap got insvc=%h nout=%0d err=%0b v=%0b exp 10/1/0/0", in_service, nout, cmpl_err, claim_valid); end
    tick();
    claim_req = 1'b0;
    n_checks++; if (claim_valid !== 1'b1 || claim_hit !== 1'b1 || claim_id !== 6'd4) begin
      n_errors++; $display("FAIL b2b_resp got v=%0b h=%0b id=%0d exp 1/1/4", claim_valid, claim_hit, claim_id); end
    tick();
    n_checks++; if (claim_valid !== 1'b0 || nout !== 7'd1 || in_service !== 64'h10 || claim_id !== 6'd4) begin
      n_errors++; $display("FAIL b2b_dropped got v=%0b nout=%0d insvc=%h id=%0d exp 0/1/10/4", claim_valid, nout, in_service, claim_id); end
    tick();
    n_checks++; if (claim_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_no_second got=%0b exp=0", claim_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    int_pend = 64'hF;
    int_en   = '1;
    tick();
    claim_pulse();
    claim_pulse();
    n_checks++; if (claim_id !== 6'd1 || nout !== 7'd2) begin
      n_errors++; $display("FAIL mid_setup got id=%0d nout=%0d exp 1/2", claim_id, nout); end
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    n_checks++; if (nout !== 7'd3 || claim_valid !== 1'b0) begin
      n_errors++; $display("FAIL mid_resp got nout=%0d v=%0b exp 3/0", nout, claim_valid); end
    rst = 1'b1;
    tick();
    n_checks++; if (claim_valid !== 1'b0 || in_service !== 64'h0 || nout !== 7'd0 || irq !== 1'b0) begin
      n_errors++; $display("FAIL mid_rst got v=%0b insvc=%h nout=%0d irq=%0b exp 0/0/0/0", claim_valid, in_service, nout, irq); end
    n_checks++; if (claim_hit !== 1'b0 || claim_id !== 6'd0) begin
      n_errors++; $display("FAIL mid_rst_claim got h=%0b id=%0d exp 0/0", claim_hit, claim_id); end
    rst = 1'b0;
    tick();
    n_checks++; if (claim_valid !== 1'b0) begin n_errors++; $display("FAIL mid_no_resp got=%0b exp=0", claim_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_enable();
    test_cmpl_err();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/intc_claim_arb.md
Name: intc_claim_arb

Overview:
- Interrupt claim/complete arbiter between the interrupt controller's `int_pend` vector and the core's trap logic.
- Masks pending sources with a per-source enable and excludes sources already in service.
- Selects the lowest-index eligible source and raises a single `irq` line.
- Runs a claim/complete handshake so each source is serviced once per claim.

Parameters:
- NSRC, 64, number of interrupt sources; width of the `int_pend`, `int_en` and in-service vectors.
- IDW, 6, source-ID width; equals clog2(NSRC).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- int_pend  in  NSRC  level pending vector from the interrupt controller
- int_en  in  NSRC  per-source enable mask
- irq  out  1  interrupt request to the core
- claim_req  in  1  single-cycle claim request from the core
- claim_valid  out  1  claim response strobe, one cycle
- claim_hit  out  1  qualifies claim_valid: 1 = a source was granted, 0 = nothing eligible
- claim_id  out  IDW  granted source ID; 0 when claim_hit=0
- cmpl_valid  in  1  completion strobe
- cmpl_id  in  IDW  completed source ID
- cmpl_err  out  1  one-cycle pulse on a completion for a source not in service
- in_service  out  NSRC  current in-service bitmap
- nout  out  IDW+1  number of sources currently in service

Behaviour:
- One clock; reset is synchronous and active-high (`rst`, sampled on the rising edge of `clk`). rst has priority over all other inputs.
- Reset values:
  - FSM = IDLE.
  - in_service = 0, nout = 0.
  - irq = 0.
  - claim_valid = claim_hit = 0, claim_id = 0.
  - cmpl_err = 0.
  - Candidate registers cleared.
- Eligibility and candidate:
  - elig = int_pend & int_en & ~in_service, evaluated combinationally each cycle.
  - Priority encoder picks the lowest set index.
  - Result is registered into cand_valid_q / cand_id_q every cycle.
  - irq = cand_valid_q, so latency from int_pend rising to irq is exactly 1 cycle.
  - Dropping int_pend or int_en also drops irq 1 cycle later.
- Claim FSM has two states, IDLE and RESP:
  - In IDLE with claim_req=1 at cycle t:
    - Capture claim_hit = cand_valid_q and claim_id = cand_valid_q ? cand_id_q : 0.
    - If a source is hit, set in_service[cand_id_q] and increment nout.
    - Go to RESP.
  - RESP at cycle t+1:
    - Drive claim_valid=1 with the captured hit/ID.
    - Go to IDLE at t+2.
    - claim_hit and claim_id hold their values until the next claim.
  - claim_req while in RESP is ignored and dropped; the requester waits for claim_valid before requesting again.
  - Grant is decided at acceptance (cycle t). A source whose int_pend drops during t+1 is still granted.
  - Back-to-back claims: a claim accepted at t+2 sees cand_q that already excludes the source granted at t.
- Completion (independent of FSM state):
  - cmpl_valid=1 and in_service[cmpl_id]=1: clear the bit, decrement nout. The bit is visible cleared next cycle; the source is eligible for irq 2 cycles after the completion.
  - cmpl_valid=1 and in_service[cmpl_id]=0: no state change; cmpl_err=1 for the following cycle.
  - cmpl_id ≥ NSRC: treated as not in service; cmpl_err is pulsed.
- Simultaneous events:
  - Claim grant of ID X and completion of ID Y≠X in the same cycle: both apply; nout is unchanged net.
  - Completion of the ID being granted in the same cycle: the granted ID cannot already be in service, so this is spurious. cmpl_err pulses and the set wins.
- nout saturates at NSRC and never underflows; it is consistent with popcount(in_service) by construction.
- Reset mid-operation, including during RESP: all state returns to reset values next cycle. A pending claim response is discarded with no claim_valid emitted.
- No combinational path from any input to any output.

Test Plan:
- Reset, then int_pend=0x…0028 (bits 3,5), int_en=all-ones → irq=1 one cycle later. claim_req pulse → claim_valid two cycles later with hit=1, id=3, in_service=0x08, nout=1.
- Continuing: second claim → id=5, nout=2. Third claim → hit=0, id=0, irq=0. cmpl_id=3 → in_service=0x20, irq returns 2 cycles later.
- int_pend bit 10 with int_en bit 10=0 → irq stays 0 and a claim returns hit=0. Set int_en bit 10 → irq=1 after 1 cycle; claim returns id=10.
- cmpl_valid with cmpl_id=7 not in service → cmpl_err pulses one cycle, in_service and nout unchanged. Same-cycle grant of id 2 plus completion of id 2 → cmpl_err=1, bit 2 set, nout=1.
- claim_req asserted on both cycles t and t+1 → only one claim_valid (the t+1 request is dropped). Same-cycle grant of 4 and completion of 9 (in service) → bit 4 set, bit 9 cleared, nout unchanged.
- Assert rst during RESP with nout=3 → no claim_valid, and next cycle in_service=0, nout=0, irq=0.
